encoder_sched: RTL
==================

# encoder_sched

Symbol scheduler and framer that feeds the 3-dimension orthogonal encoder. It accepts a byte stream over a valid/ready handshake and repacks it into 5-bit symbols through an 8→5 gearbox. It wraps each frame with preamble and end-of-frame symbols and issues one symbol per symbol period. It sits between the MAC-side byte source and the encoder's `data` input, and is the only block that drives the encoder.

## Interface
- `SYM_WIDTH`, 5: symbol width; equals the encoder `BITS_WIDTH`.
- `SYM_DIV`, 4: clocks per symbol period; legal range 2..255.
- `PRE_LEN`, 4: preamble symbols per frame; legal range 1..15.
- `PRE_A`, 5'h15: even-index preamble symbol.
- `PRE_B`, 5'h0A: odd-index preamble symbol.
- `EOF_SYM`, 5'h1F: end-of-frame symbol.
- `IDLE_SYM`, 5'h00: symbol driven when idle or on underrun.

Ports:
- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `s_data`  in  8  payload byte.
- `s_valid`  in  1  byte valid.
- `s_last`  in  1  byte is last of frame; qualified by `s_valid`.
- `s_ready`  out  1  byte accepted when `s_valid & s_ready`.
- `sym`  out  SYM_WIDTH  symbol to encoder `data`.
- `sym_stb`  out  1  one-clock pulse; `sym` is new this cycle.
- `sym_sof`  out  1  `sym` is the first preamble symbol.
- `sym_eof`  out  1  `sym` is `EOF_SYM` (the frame marker, not payload 5'h1F).
- `busy`  out  1  a frame is in progress (state ≠ IDLE).
- `underrun`  out  1  one-clock pulse; a payload symbol was due but data was short.

## Operation
- **Symbol timer.** A divider counts 0..SYM_DIV-1 and wraps; `tick` = (count == SYM_DIV-1). It free-runs in every state.
- **State IDLE.** On a tick with `s_valid`=1, go to PRE with index 0. Otherwise emit `IDLE_SYM`.
- **State PRE.** Each tick emits `PRE_A` for even index and `PRE_B` for odd index. `sym_sof` is set at index 0. After PRE_LEN symbols, go to PAY.
- **Gearbox.** A 12-bit bit buffer with count `cnt` (0..12) is packed LSB-first: each new byte is ORed in at bit position `cnt`.
- **Buffer consumption.** Each emitted symbol takes `buf[4:0]`, shifts the buffer right by 5, and does `cnt -= 5`.
- **`s_ready`.** `s_ready` = (state==PRE or PAY) & !last_seen & cnt<5.
- **Last byte.** Accepting a byte with `s_last`=1 sets `last_seen`.
- **State PAY, on each tick:**
  - cnt≥5: emit `buf[4:0]`.
  - else if `last_seen` and cnt>0: emit `buf[4:0]` zero-padded above `cnt`, set cnt=0, go to EOF.
  - else if `last_seen` and cnt=0: go to EOF; this tick emits `EOF_SYM` directly.
  - else (data short): emit `IDLE_SYM`, pulse `underrun`, remain in PAY.
- **State EOF.** Emit `EOF_SYM` with `sym_eof`=1. Clear `last_seen` and the buffer, then go to IDLE. The next frame can start on the next tick at the earliest.
- **Same-cycle accept and consume.** A byte accepted in the same cycle as a tick consumption is merged at the post-consumption `cnt`.

## Timing
- All outputs are registered.
- **Symbol latency.** On a tick edge, `sym`, `sym_sof`, `sym_eof`, `sym_stb` and `underrun` update together and are held until the next tick. `sym_stb` is high for exactly that one cycle.
- **Start latency.** The first preamble symbol appears on the first tick at or after `s_valid` rises. The first payload symbol appears PRE_LEN ticks later.
- **Handshake.**
  - `s_valid` and `s_data` must hold until accepted.
  - `s_ready` may drop on any cycle.
  - At most one byte is accepted per clock.
- **Reset values:** `sym`=`IDLE_SYM`, `sym_stb`=0, `sym_sof`=0, `sym_eof`=0, `busy`=0, `underrun`=0, `s_ready`=0, divider=0, cnt=0, state IDLE.
- **Reset mid-frame.** Abort immediately. No EOF is emitted and the buffered bits are discarded.

## Structure
- Shared package `encoder_pkg` holds:
  - the state enum {IDLE, PRE, PAY, EOF};
  - the `SYM_WIDTH` constant;
  - the default symbol constants.
- Sub-module `sym_gearbox` holds the 8→5 buffer, `cnt`, the merge and shift, and pad logic. The top level holds the FSM, divider and output registers.

## Test plan
- **Single-byte frame.** Reset with defaults, then send byte 0xA5 with last. Required `sym` sequence at ticks: 15, 0A, 15, 0A, 05, 05, 1F. `sym_sof` on the first symbol, `sym_eof` on the last, then 00.
- **Two-byte frame.** Send 0xFF, then 0x01 with last. Payload is 1F, 0F, 00, 00 (the final 00 carries padding), then 1F with `sym_eof`=1. The payload 1F has `sym_eof`=0.
- **Underrun.** Send byte 0x00, then stall `s_valid` for 3 ticks, then send 0x00 with last. Payload is 00 followed by three `IDLE_SYM` with `underrun` pulses, and the frame completes.
- **Back-pressure.** Hold `s_valid` continuously. `s_ready` never asserts while cnt≥5, and no byte is lost or duplicated across a 20-byte random frame (compare against a reference bit-packer).
- **Reset mid-frame.** Assert `rst` low during PAY. Outputs reach reset values immediately. After release, a new frame starts cleanly with `sym_sof`.
- **Timer.** With SYM_DIV=2, `sym_stb` has a period of exactly 2 clocks across a full frame.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared types and default symbol values for the encoder symbol scheduler.
package encoder_pkg;

    localparam int SYM_WIDTH = 5;

    typedef enum logic [1:0] {IDLE, PRE, PAY, EOF} state_t;

    localparam logic [SYM_WIDTH-1:0] DEF_PRE_A    = 5'h15;
    localparam logic [SYM_WIDTH-1:0] DEF_PRE_B    = 5'h0A;
    localparam logic [SYM_WIDTH-1:0] DEF_EOF_SYM  = 5'h1F;
    localparam logic [SYM_WIDTH-1:0] DEF_IDLE_SYM = 5'h00;

endpackage

// File: rtl/sym_gearbox.sv
// 8->5 gearbox: LSB-first bit buffer that merges bytes in and hands out
// zero-padded symbols from its bottom bits.
module sym_gearbox
    import encoder_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_accept,
    input  logic [7:0]           i_byte,
    input  logic                 i_consume,
    input  logic                 i_clear,
    output logic [SYM_WIDTH-1:0] o_sym,
    output logic [3:0]           o_cnt
);

    localparam int BUF_W = 12;

    logic [BUF_W-1:0] r_buf;
    logic [3:0]       r_cnt;
    logic [BUF_W-1:0] w_bufBase;
    logic [BUF_W-1:0] w_bufNext;
    logic [3:0]       w_cntBase;
    logic [3:0]       w_cntNext;

    // Consumption happens first so a byte taken on the same edge lands at the post-shift count.
    always_comb begin
        w_bufBase = r_buf;
        w_cntBase = r_cnt;
        if (i_clear) begin
            w_bufBase = '0;
            w_cntBase = '0;
        end else if (i_consume) begin
            w_bufBase = r_buf >> SYM_WIDTH;
            w_cntBase = r_cnt - 4'(SYM_WIDTH);
        end
        w_bufNext = w_bufBase;
        w_cntNext = w_cntBase;
        if (i_accept) begin
            w_bufNext = w_bufBase | (BUF_W'(i_byte) << w_cntBase);
            w_cntNext = w_cntBase + 4'd8;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf <= '0;
            r_cnt <= '0;
        end else begin
            r_buf <= w_bufNext;
            r_cnt <= w_cntNext;
        end
    end

    assign o_sym = r_buf[SYM_WIDTH-1:0] & ~({SYM_WIDTH{1'b1}} << r_cnt);
    assign o_cnt = r_cnt;

endmodule

// File: rtl/encoder_sched.sv
// Frames a byte stream into preamble / payload / EOF symbols for the
// orthogonal encoder, issuing one registered symbol per symbol period.
module encoder_sched
    import encoder_pkg::*;
#(
    parameter int                   SYM_DIV  = 4,
    parameter int                   PRE_LEN  = 4,
    parameter logic [SYM_WIDTH-1:0] PRE_A    = DEF_PRE_A,
    parameter logic [SYM_WIDTH-1:0] PRE_B    = DEF_PRE_B,
    parameter logic [SYM_WIDTH-1:0] EOF_SYM  = DEF_EOF_SYM,
    parameter logic [SYM_WIDTH-1:0] IDLE_SYM = DEF_IDLE_SYM
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           s_data,
    input  logic                 s_valid,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic [SYM_WIDTH-1:0] sym,
    output logic                 sym_stb,
    output logic                 sym_sof,
    output logic                 sym_eof,
    output logic                 busy,
    output logic                 underrun
);

    state_t               r_state;
    state_t               w_nextState;
    logic [3:0]           r_idx;
    logic [3:0]           w_nextIdx;
    logic [7:0]           r_div;
    logic                 r_lastSeen;
    logic [SYM_WIDTH-1:0] r_sym;
    logic                 r_stb;
    logic                 r_sof;
    logic                 r_eof;
    logic                 r_underrun;

    logic                 w_tick;
    logic                 w_accept;
    logic                 w_consume;
    logic                 w_clear;
    logic [SYM_WIDTH-1:0] w_symNext;
    logic                 w_sofNext;
    logic                 w_eofNext;
    logic                 w_urNext;
    logic [SYM_WIDTH-1:0] w_gbSym;
    logic [3:0]           w_cnt;

    assign w_tick   = (r_div == 8'(SYM_DIV - 1));
    assign s_ready  = (r_state == PRE || r_state == PAY) && !r_lastSeen && (w_cnt < 4'd5);
    assign w_accept = s_valid && s_ready;

    sym_gearbox u_gearbox (
        .clk      (clk),
        .rst      (rst),
        .i_accept (w_accept),
        .i_byte   (s_data),
        .i_consume(w_consume),
        .i_clear  (w_clear),
        .o_sym    (w_gbSym),
        .o_cnt    (w_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_nextState;
            r_idx   <= w_nextIdx;
        end
    end

    // The start tick itself carries preamble symbol 0, so PRE resumes at index 1.
    always_comb begin
        w_nextState = r_state;
        w_nextIdx   = r_idx;
        w_symNext   = IDLE_SYM;
        w_sofNext   = 1'b0;
        w_eofNext   = 1'b0;
        w_urNext    = 1'b0;
        w_consume   = 1'b0;
        w_clear     = 1'b0;
        if (w_tick) begin
            case (r_state)
                IDLE: begin
                    if (s_valid) begin
                        w_symNext = PRE_A;
                        w_sofNext = 1'b1;
                        if (PRE_LEN == 1) begin
                            w_nextState = PAY;
                        end else begin
                            w_nextState = PRE;
                            w_nextIdx   = 4'd1;
                        end
                    end
                end
                PRE: begin
                    w_symNext = r_idx[0] ? PRE_B : PRE_A;
                    if (r_idx == 4'(PRE_LEN - 1)) begin
                        w_nextState = PAY;
                        w_nextIdx   = '0;
                    end else begin
                        w_nextIdx = r_idx + 4'd1;
                    end
                end
                PAY: begin
                    if (w_cnt >= 4'd5) begin
                        w_symNext = w_gbSym;
                        w_consume = 1'b1;
                    end else if (r_lastSeen && w_cnt != 4'd0) begin
                        w_symNext   = w_gbSym;
                        w_clear     = 1'b1;
                        w_nextState = EOF;
                    end else if (r_lastSeen) begin
                        w_symNext   = EOF_SYM;
                        w_eofNext   = 1'b1;
                        w_clear     = 1'b1;
                        w_nextState = IDLE;
                    end else begin
                        w_urNext = 1'b1;
                    end
                end
                EOF: begin
                    w_symNext   = EOF_SYM;
                    w_eofNext   = 1'b1;
                    w_clear     = 1'b1;
                    w_nextState = IDLE;
                end
                default: w_nextState = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div      <= '0;
            r_lastSeen <= 1'b0;
            r_sym      <= IDLE_SYM;
            r_stb      <= 1'b0;
            r_sof      <= 1'b0;
            r_eof      <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_div <= w_tick ? 8'd0 : r_div + 8'd1;
            if (w_clear) begin
                r_lastSeen <= 1'b0;
            end else if (w_accept && s_last) begin
                r_lastSeen <= 1'b1;
            end
            r_stb      <= w_tick;
            r_underrun <= w_tick && w_urNext;
            if (w_tick) begin
                r_sym <= w_symNext;
                r_sof <= w_sofNext;
                r_eof <= w_eofNext;
            end
        end
    end

    assign sym      = r_sym;
    assign sym_stb  = r_stb;
    assign sym_sof  = r_sof;
    assign sym_eof  = r_eof;
    assign underrun = r_underrun;
    assign busy     = (r_state != IDLE);

endmodule
